// File: rtl/tl_arbiter_2to1_if.sv
// tl_arbiter_2to1_if: one TileLink-UL A/D port; source width is set per instance
interface tl_arbiter_2to1_if #(
   parameter int ADDR_W = 31,
   parameter int DATA_W = 64,
   parameter int SRC_W  = 3
);
   logic                a_ready;
   logic                a_valid;
   logic [2:0]          a_opcode;
   logic [2:0]          a_param;
   logic [2:0]          a_size;
   logic [SRC_W-1:0]    a_source;
   logic [ADDR_W-1:0]   a_address;
   logic [DATA_W/8-1:0] a_mask;
   logic [DATA_W-1:0]   a_data;
   logic                a_corrupt;
   logic                d_ready;
   logic                d_valid;
   logic [2:0]          d_opcode;
   logic [1:0]          d_param;
   logic [2:0]          d_size;
   logic [SRC_W-1:0]    d_source;
   logic                d_sink;
   logic                d_denied;
   logic [DATA_W-1:0]   d_data;
   logic                d_corrupt;
   modport master (
      input  a_ready,
      output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
      output d_ready,
      input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt
   );
   modport slave (
      output a_ready,
      input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
      input  d_ready,
      output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt
   );
endinterface

// File: rtl/tl_arbiter_2to1.sv
// tl_arbiter_2to1: two-client TL-UL arbiter, round-robin with burst lock; TL_ARBITER_FIXED_PRIO_EN makes client 0 win ties
module tl_arbiter_2to1 #(
   parameter int ADDR_W = 31,
   parameter int DATA_W = 64,
   parameter int SRC_W  = 3
) (
   input logic               clock,
   input logic               reset,
   tl_arbiter_2to1_if.slave  in0,
   tl_arbiter_2to1_if.slave  in1,
   tl_arbiter_2to1_if.master out
);
   typedef enum logic [1:0] {IDLE, HOLD, BURST} state_e;
   typedef struct packed {
      logic [2:0]          opcode;
      logic [2:0]          param;
      logic [2:0]          size;
      logic [SRC_W-1:0]    source;
      logic [ADDR_W-1:0]   address;
      logic [DATA_W/8-1:0] mask;
      logic [DATA_W-1:0]   data;
      logic                corrupt;
   } a_t;
   state_e     state_q, state_d;
   logic       owner_q, owner_d, rr_last_q, rr_last_d;
   logic [4:0] beats_left_q, beats_left_d, beats;
   logic       tie_pick, grant, busy, fire, sel;
   a_t         a0, a1, a_sel;
`ifdef TL_ARBITER_FIXED_PRIO_EN
   assign tie_pick = 1'b0;
`else
   assign tie_pick = ~rr_last_q;
`endif
   assign a0 = {in0.a_opcode, in0.a_param, in0.a_size, in0.a_source, in0.a_address, in0.a_mask, in0.a_data, in0.a_corrupt};
   assign a1 = {in1.a_opcode, in1.a_param, in1.a_size, in1.a_source, in1.a_address, in1.a_mask, in1.a_data, in1.a_corrupt};
   assign grant = (state_q != IDLE) ? owner_q : (in0.a_valid && in1.a_valid) ? tie_pick : in1.a_valid;
   assign a_sel = grant ? a1 : a0;
   assign busy  = (state_q != IDLE) || in0.a_valid || in1.a_valid;
   assign out.a_valid   = grant ? in1.a_valid : in0.a_valid;
   assign out.a_opcode  = a_sel.opcode;
   assign out.a_param   = a_sel.param;
   assign out.a_size    = a_sel.size;
   assign out.a_source  = {grant, a_sel.source};
   assign out.a_address = a_sel.address;
   assign out.a_mask    = a_sel.mask;
   assign out.a_data    = a_sel.data;
   assign out.a_corrupt = a_sel.corrupt;
   assign in0.a_ready   = !grant && busy && out.a_ready;
   assign in1.a_ready   = grant && busy && out.a_ready;
   assign fire  = out.a_valid && out.a_ready;
   // only PutFull/PutPartial carry multiple data beats
   assign beats = (a_sel.opcode[2:1] == 2'b00 && a_sel.size > 3'd3) ? 5'd1 << (a_sel.size - 3'd3) : 5'd1;
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      rr_last_d    = rr_last_q;
      beats_left_d = beats_left_q;
      if (state_q == BURST) begin
         if (fire) begin
            beats_left_d = beats_left_q - 5'd1;
            if (beats_left_q == 5'd1) begin
               state_d   = IDLE;
               rr_last_d = owner_q;
            end
         end
      end else if (fire && beats != 5'd1) begin
         state_d      = BURST;
         beats_left_d = beats - 5'd1;
         owner_d      = grant;
      end else if (fire) begin
         state_d   = IDLE;
         rr_last_d = grant;
      end else if (out.a_valid) begin
         state_d = HOLD;
         owner_d = grant;
      end
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         rr_last_q    <= 1'b1;
         beats_left_q <= 5'd0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         rr_last_q    <= rr_last_d;
         beats_left_q <= beats_left_d;
      end
   end
   // D responses route on the client-index bit added to the source on A
   assign sel = out.d_source[SRC_W];
   assign out.d_ready   = sel ? in1.d_ready : in0.d_ready;
   assign in0.d_valid   = out.d_valid && !sel;
   assign in1.d_valid   = out.d_valid && sel;
   assign in0.d_opcode  = out.d_opcode;
   assign in1.d_opcode  = out.d_opcode;
   assign in0.d_param   = out.d_param;
   assign in1.d_param   = out.d_param;
   assign in0.d_size    = out.d_size;
   assign in1.d_size    = out.d_size;
   assign in0.d_source  = out.d_source[SRC_W-1:0];
   assign in1.d_source  = out.d_source[SRC_W-1:0];
   assign in0.d_sink    = out.d_sink;
   assign in1.d_sink    = out.d_sink;
   assign in0.d_denied  = out.d_denied;
   assign in1.d_denied  = out.d_denied;
   assign in0.d_data    = out.d_data;
   assign in1.d_data    = out.d_data;
   assign in0.d_corrupt = out.d_corrupt;
   assign in1.d_corrupt = out.d_corrupt;
endmodule

// File: tb/tb_tl_arbiter_2to1.sv
// tb_tl_arbiter_2to1: directed and random checks of the 2:1 TL arbiter against a transaction-level model
module tb_tl_arbiter_2to1;
`ifdef TL_ARBITER_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;
   logic        v[2], drdy[2], fired[2];
   logic [2:0]  op[2], sz[2], src[2];
   logic [30:0] addr[2];
   logic [63:0] data[2];
   logic [7:0]  mask[2];
   logic        ordy, dv;
   logic [3:0]  dsrc;
   logic [63:0] ddata;
   int total = 0, bad = 0;
   int lock = -1, rem = 0, last = 1;
   int left[2];
   tl_arbiter_2to1_if #(.SRC_W(3)) in0_if ();
   tl_arbiter_2to1_if #(.SRC_W(3)) in1_if ();
   tl_arbiter_2to1_if #(.SRC_W(4)) out_if ();
   assign in0_if.a_valid   = v[0];
   assign in0_if.a_opcode  = op[0];
   assign in0_if.a_param   = 3'd0;
   assign in0_if.a_size    = sz[0];
   assign in0_if.a_source  = src[0];
   assign in0_if.a_address = addr[0];
   assign in0_if.a_mask    = mask[0];
   assign in0_if.a_data    = data[0];
   assign in0_if.a_corrupt = 1'b0;
   assign in0_if.d_ready   = drdy[0];
   assign in1_if.a_valid   = v[1];
   assign in1_if.a_opcode  = op[1];
   assign in1_if.a_param   = 3'd0;
   assign in1_if.a_size    = sz[1];
   assign in1_if.a_source  = src[1];
   assign in1_if.a_address = addr[1];
   assign in1_if.a_mask    = mask[1];
   assign in1_if.a_data    = data[1];
   assign in1_if.a_corrupt = 1'b0;
   assign in1_if.d_ready   = drdy[1];
   assign out_if.a_ready   = ordy;
   assign out_if.d_valid   = dv;
   assign out_if.d_opcode  = 3'd1;
   assign out_if.d_param   = 2'd0;
   assign out_if.d_size    = 3'd3;
   assign out_if.d_source  = dsrc;
   assign out_if.d_sink    = 1'b0;
   assign out_if.d_denied  = dsrc[0];
   assign out_if.d_data    = ddata;
   assign out_if.d_corrupt = 1'b0;
   tl_arbiter_2to1 dut (.clock(clock), .reset(reset), .in0(in0_if), .in1(in1_if), .out(out_if));
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic int nbeats(input logic [2:0] o, input logic [2:0] s);
      return (o <= 3'd1 && s > 3'd3) ? (1 << (int'(s) - 3)) : 1;
   endfunction
   // who owns the port: the locked transaction, else the sole requester, else the tie rule
   function automatic int mgrant();
      if (lock >= 0) return lock;
      if (v[0] && v[1]) return FIXED ? 0 : 1 - last;
      return v[1] ? 1 : 0;
   endfunction
   task automatic cycle();
      int g;
      logic busy;
      #1;
      g = mgrant();
      busy = (lock >= 0) || v[0] || v[1];
      chk("a_valid", out_if.a_valid, v[g]);
      chk("a_source", out_if.a_source, {g[0], src[g]});
      chk("a_address", out_if.a_address, addr[g]);
      chk("a_data", out_if.a_data, data[g]);
      chk("in0_a_ready", in0_if.a_ready, g == 0 && busy && ordy);
      chk("in1_a_ready", in1_if.a_ready, g == 1 && busy && ordy);
      chk("in0_d_valid", in0_if.d_valid, dv && !dsrc[3]);
      chk("in1_d_valid", in1_if.d_valid, dv && dsrc[3]);
      chk("in0_d_source", in0_if.d_source, dsrc[2:0]);
      chk("in1_d_data", in1_if.d_data, ddata);
      chk("out_d_ready", out_if.d_ready, dsrc[3] ? drdy[1] : drdy[0]);
      fired[0] = 1'b0;
      fired[1] = 1'b0;
      if (lock < 0 && v[g]) begin
         lock = g;
         rem  = nbeats(op[g], sz[g]);
      end
      if (v[g] && ordy) begin
         fired[g] = 1'b1;
         rem--;
         if (rem == 0) begin
            lock = -1;
            last = g;
         end
      end
      @(posedge clock);
      @(negedge clock);
   endtask
   task automatic get(input int c, input logic [2:0] s, input logic [30:0] a);
      v[c] = 1'b1; op[c] = 3'd4; sz[c] = 3'd3; src[c] = s; addr[c] = a;
      mask[c] = 8'hff; data[c] = {$urandom, $urandom};
   endtask
   initial begin
      for (int c = 0; c < 2; c++) begin
         v[c] = 0; drdy[c] = 0; op[c] = 0; sz[c] = 0; src[c] = 0;
         addr[c] = 0; data[c] = 0; mask[c] = 0; left[c] = 0; fired[c] = 0;
      end
      ordy = 1; dv = 0; dsrc = 0; ddata = 0;
      repeat (2) @(negedge clock);
      #1;
      chk("rst_a_valid", out_if.a_valid, 0);
      chk("rst_in0_a_ready", in0_if.a_ready, 0);
      chk("rst_in1_a_ready", in1_if.a_ready, 0);
      chk("rst_beats_left", dut.beats_left_q, 0);
      reset = 1;
      @(negedge clock);
      cycle();
      get(0, 3'd5, 31'h100);
      get(1, 3'd2, 31'h200);
      #1 chk("first_tie", out_if.a_source, 4'h5);
      cycle();
      #1 chk("second_tie", out_if.a_source, FIXED ? 4'h5 : 4'hA);
      cycle();
      v[0] = 0; v[1] = 0;
      cycle();
      v[1] = 1; op[1] = 3'd0; sz[1] = 3'd5; src[1] = 3'd3; addr[1] = 31'h340; data[1] = {$urandom, $urandom};
      cycle();
      get(0, 3'd1, 31'h400);
      for (int i = 0; i < 3; i++) begin
         data[1] = {$urandom, $urandom};
         #1 chk("burst_owner", out_if.a_source[3], 1);
         chk("burst_in0_blocked", in0_if.a_ready, 0);
         cycle();
      end
      v[1] = 0;
      #1 chk("after_burst", out_if.a_source, 4'h1);
      cycle();
      v[0] = 0;
      cycle();
      ordy = 0;
      get(0, 3'd6, 31'h5a5);
      cycle();
      get(1, 3'd7, 31'h0f0);
      for (int i = 0; i < 2; i++) begin
         #1 chk("hold_src", out_if.a_source, 4'h6);
         chk("hold_addr", out_if.a_address, 31'h5a5);
         chk("hold_in1_ready", in1_if.a_ready, 0);
         cycle();
      end
      ordy = 1;
      cycle();
      cycle();
      v[0] = 0; v[1] = 0;
      cycle();
      dv = 1; dsrc = 4'b1010; drdy[1] = 1; drdy[0] = 0; ddata = 64'hdead_beef_0123_4567;
      #1 chk("d_in1_valid", in1_if.d_valid, 1);
      chk("d_in1_source", in1_if.d_source, 3'b010);
      chk("d_in0_valid", in0_if.d_valid, 0);
      chk("d_ready_hi", out_if.d_ready, 1);
      cycle();
      drdy[1] = 0;
      #1 chk("d_ready_lo", out_if.d_ready, 0);
      cycle();
      dv = 0;
      v[0] = 1; op[0] = 3'd0; sz[0] = 3'd5; src[0] = 3'd4; addr[0] = 31'h800; data[0] = {$urandom, $urandom};
      cycle();
      data[0] = {$urandom, $urandom};
      cycle();
      #2 reset = 0;
      #1 chk("rst_mid_beats_left", dut.beats_left_q, 0);
      reset = 1;
      lock = -1; rem = 0; last = 1;
      v[0] = 0;
      @(negedge clock);
      get(0, 3'd0, 31'h10);
      get(1, 3'd1, 31'h20);
      for (int i = 0; i < 8; i++) begin
         #1 chk("tie_stream", out_if.a_source[3], FIXED ? 0 : i % 2);
         cycle();
      end
      v[0] = 0; v[1] = 0;
      cycle();
      left[0] = 0; left[1] = 0;
      for (int n = 0; n < 600; n++) begin
         for (int c = 0; c < 2; c++) begin
            if (!v[c]) begin
               if (left[c] > 0) begin
                  if ($urandom % 4 != 0) begin
                     v[c] = 1;
                     data[c] = {$urandom, $urandom};
                  end
               end else if ($urandom % 2 == 1) begin
                  op[c] = ($urandom % 3 == 0) ? 3'd4 : 3'($urandom % 2);
                  sz[c] = 3'($urandom % 6);
                  src[c] = 3'($urandom);
                  addr[c] = 31'($urandom);
                  mask[c] = 8'($urandom);
                  data[c] = {$urandom, $urandom};
                  left[c] = nbeats(op[c], sz[c]);
                  v[c] = 1;
               end
            end
            drdy[c] = 1'($urandom);
         end
         ordy = ($urandom % 4 != 0);
         dv = 1'($urandom);
         dsrc = 4'($urandom);
         ddata = {$urandom, $urandom};
         cycle();
         for (int c = 0; c < 2; c++) if (fired[c]) begin
            left[c]--;
            v[c] = 0;
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
